// File: rtl/bsg_mux2_gatestack_rr_ctrl.sv
// Round-robin, packet-locking arbiter driving a shared width_p-bit 2:1 gatestack mux.
// Optional per-requester completed-packet counters under BSG_MUX2_RR_CTRL_STATS_EN.
module bsg_mux2_gatestack_rr_ctrl #(
  parameter int width_p = 3,
  parameter bit lock_p  = 1'b1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v0_i,
  input  logic [width_p-1:0] data0_i,
  input  logic               last0_i,
  output logic               ready0_o,
  input  logic               v1_i,
  input  logic [width_p-1:0] data1_i,
  input  logic               last1_i,
  output logic               ready1_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               last_o,
  input  logic               ready_i,
`ifdef BSG_MUX2_RR_CTRL_STATS_EN
  input  logic               stats_clr_i,
  output logic [15:0]        pkt_cnt0_o,
  output logic [15:0]        pkt_cnt1_o,
`endif
  output logic [width_p-1:0] sel_o
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

  state_e r_state, w_state_nxt;
  logic   r_prio, w_prio_nxt;
  logic   w_g, w_v, w_last, w_accept;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    w_g         = r_prio;
    w_state_nxt = r_state;
    w_prio_nxt  = r_prio;

    unique case (r_state)
      IDLE: begin
        if (v0_i && !v1_i)      w_g = 1'b0;
        else if (v1_i && !v0_i) w_g = 1'b1;
      end
      LOCK0:   w_g = 1'b0;
      LOCK1:   w_g = 1'b1;
      default: w_g = r_prio;
    endcase

    // Outputs are combinational, so gate them while reset is held.
    if (!reset_n_i) w_g = 1'b0;

    w_v      = reset_n_i & (w_g ? v1_i : v0_i);
    w_last   = w_g ? last1_i : last0_i;
    w_accept = w_v & ready_i;

    if (w_accept) begin
      if (r_state == IDLE && lock_p && !w_last) begin
        w_state_nxt = w_g ? LOCK1 : LOCK0;
      end else if (r_state == IDLE || w_last) begin
        w_state_nxt = IDLE;
        w_prio_nxt  = ~w_g;
      end
    end
  end

  assign v_o      = w_v;
  assign last_o   = w_last;
  assign ready0_o = reset_n_i & ready_i & ~w_g;
  assign ready1_o = reset_n_i & ready_i &  w_g;
  assign sel_o    = {width_p{w_g}};
  assign data_o   = (sel_o & data1_i) | (~sel_o & data0_i);

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
      r_prio  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_prio  <= w_prio_nxt;
    end
  end

`ifdef BSG_MUX2_RR_CTRL_STATS_EN
  logic w_done;
  assign w_done = w_accept & w_last;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pkt_cnt0_o <= '0;
      pkt_cnt1_o <= '0;
    end else if (stats_clr_i) begin
      pkt_cnt0_o <= '0;
      pkt_cnt1_o <= '0;
    end else if (w_done) begin
      // Counters saturate rather than wrap.
      if (!w_g && pkt_cnt0_o != 16'hFFFF) pkt_cnt0_o <= pkt_cnt0_o + 16'd1;
      if ( w_g && pkt_cnt1_o != 16'hFFFF) pkt_cnt1_o <= pkt_cnt1_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mux2_gatestack_rr_ctrl.sv
// Scoreboard bench: stimulus pushes expected accepted beats; a monitor pops and compares on each accept.
module tb_bsg_mux2_gatestack_rr_ctrl;

  localparam int W = 3;

  typedef struct {
    logic         g;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v0, last0, v1, last1, ready_in;
  logic [W-1:0] d0, d1;
  logic         ready0, ready1, v_out, last_out;
  logic [W-1:0] data_out, sel;
`ifdef BSG_MUX2_RR_CTRL_STATS_EN
  logic         stats_clr = 1'b0;
  logic [15:0]  cnt0, cnt1;
`endif

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  bsg_mux2_gatestack_rr_ctrl #(.width_p(W), .lock_p(1'b1)) dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .v0_i(v0), .data0_i(d0), .last0_i(last0), .ready0_o(ready0),
    .v1_i(v1), .data1_i(d1), .last1_i(last1), .ready1_o(ready1),
    .v_o(v_out), .data_o(data_out), .last_o(last_out), .ready_i(ready_in),
`ifdef BSG_MUX2_RR_CTRL_STATS_EN
    .stats_clr_i(stats_clr), .pkt_cnt0_o(cnt0), .pkt_cnt1_o(cnt1),
`endif
    .sel_o(sel)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic a_v0, input logic [W-1:0] a_d0, input logic a_l0,
                       input logic a_v1, input logic [W-1:0] a_d1, input logic a_l1,
                       input logic a_rdy);
    v0 = a_v0; d0 = a_d0; last0 = a_l0;
    v1 = a_v1; d1 = a_d1; last1 = a_l1;
    ready_in = a_rdy;
  endtask

  task automatic expect_beat(input logic g, input logic [W-1:0] data, input logic last);
    beat_t b;
    b.g = g; b.data = data; b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard.
  initial begin
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst_n && v_out && ready_in) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sel=%0h data=%0h expected none", sel, data_out);
        end else begin
          b = exp_q.pop_front();
          check("beat_sel",  {29'd0, sel},      {29'd0, {W{b.g}}});
          check("beat_data", {29'd0, data_out}, {29'd0, b.data});
          check("beat_last", {31'd0, last_out}, {31'd0, b.last});
        end
      end
    end
  end

  initial begin
    // Reset with both requesters valid: everything held off.
    rst_n = 1'b0;
    drive(1'b1, 3'b001, 1'b1, 1'b1, 3'b110, 1'b1, 1'b1);
    #3;
    check("rst_ready0", {31'd0, ready0}, 32'd0);
    check("rst_ready1", {31'd0, ready1}, 32'd0);
    check("rst_v_o",    {31'd0, v_out},  32'd0);
    check("rst_sel",    {29'd0, sel},    32'd0);
    check("rst_data",   {29'd0, data_out}, 32'h1);
    tick();

    // Single-beat packets from both: grants alternate 0,1,0,1.
    expect_beat(1'b0, 3'b001, 1'b1);
    rst_n = 1'b1;
    tick();
    drive(1'b1, 3'b010, 1'b1, 1'b1, 3'b101, 1'b1, 1'b1);
    expect_beat(1'b1, 3'b101, 1'b1);
    tick();
    drive(1'b1, 3'b011, 1'b1, 1'b1, 3'b100, 1'b1, 1'b1);
    expect_beat(1'b0, 3'b011, 1'b1);
    tick();
    drive(1'b1, 3'b000, 1'b1, 1'b1, 3'b111, 1'b1, 1'b1);
    expect_beat(1'b1, 3'b111, 1'b1);
    tick();

    // Three-beat packet from requester 0 while requester 1 waits.
    drive(1'b1, 3'b100, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1);
    expect_beat(1'b0, 3'b100, 1'b0);
    #2 check("lock0_ready1_a", {31'd0, ready1}, 32'd0);
    tick();
    drive(1'b1, 3'b101, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1);
    expect_beat(1'b0, 3'b101, 1'b0);
    #2 check("lock0_ready1_b", {31'd0, ready1}, 32'd0);
    tick();
    drive(1'b1, 3'b110, 1'b1, 1'b1, 3'b011, 1'b1, 1'b1);
    expect_beat(1'b0, 3'b110, 1'b1);
    #2 check("lock0_ready1_c", {31'd0, ready1}, 32'd0);
    tick();
    drive(1'b0, 3'b000, 1'b0, 1'b1, 3'b011, 1'b1, 1'b1);
    expect_beat(1'b1, 3'b011, 1'b1);
    tick();

    // Lock to requester 1, then a two-cycle valid gap must not leak a grant to requester 0.
    drive(1'b0, 3'b000, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1);
    expect_beat(1'b1, 3'b010, 1'b0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
      #2;
      check("gap_v_o",    {31'd0, v_out},  32'd0);
      check("gap_ready0", {31'd0, ready0}, 32'd0);
      check("gap_sel",    {29'd0, sel},    32'h7);
      tick();
    end
    drive(1'b1, 3'b001, 1'b1, 1'b1, 3'b101, 1'b1, 1'b1);
    expect_beat(1'b1, 3'b101, 1'b1);
    tick();

    // Downstream stall with both valid: grant and data stay on requester 0.
    drive(1'b1, 3'b110, 1'b1, 1'b1, 3'b011, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #2;
      check("stall_sel",  {29'd0, sel},      32'h0);
      check("stall_data", {29'd0, data_out}, 32'h6);
      check("stall_v_o",  {31'd0, v_out},    32'd1);
      tick();
    end
    ready_in = 1'b1;
    expect_beat(1'b0, 3'b110, 1'b1);
    tick();
    expect_beat(1'b1, 3'b011, 1'b1);
    tick();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    #2 check("idle_v_o", {31'd0, v_out}, 32'd0);
    tick();

`ifdef BSG_MUX2_RR_CTRL_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr0_a", {16'd0, cnt0}, 32'd0);
    check("stats_clr1_a", {16'd0, cnt1}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
      expect_beat(1'b0, W'(i), 1'b1);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 3'b000, 1'b0, 1'b1, W'(i + 5), 1'b1, 1'b1);
      expect_beat(1'b1, W'(i + 5), 1'b1);
      tick();
    end
    drive(1'b0, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    check("stats_cnt0", {16'd0, cnt0}, 32'd5);
    check("stats_cnt1", {16'd0, cnt1}, 32'd2);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("stats_clr0_b", {16'd0, cnt0}, 32'd0);
    check("stats_clr1_b", {16'd0, cnt1}, 32'd0);
`endif

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_mux2_gatestack_rr_ctrl.md
Name: bsg_mux2_gatestack_rr_ctrl

Overview:
- Round-robin, packet-locking arbiter that shares one width_p-bit 2:1 gatestack mux between two ready/valid requesters.
- Generates the per-bit select vector (all bits equal to the grant) and steers the winner's data onto a single output channel.
- The grant is held from the first beat of a packet until its last beat is accepted.
- Sits between two producer channels and one downstream consumer, for example a shared network or memory port.

Parameters:
width_p, 3, data width per beat; also the width of the select vector.
lock_p, 1, 1 = hold grant until last beat; 0 = re-arbitrate every beat (last inputs ignored).

Ports:
clk_i  input  1  clock, rising edge.
reset_n_i  input  1  asynchronous active-low reset.
v0_i  input  1  requester 0 valid.
data0_i  input  width_p  requester 0 data.
last0_i  input  1  requester 0 final beat of packet.
ready0_o  output  1  requester 0 accepted this cycle when v0_i&ready0_o.
v1_i  input  1  requester 1 valid.
data1_i  input  width_p  requester 1 data.
last1_i  input  1  requester 1 final beat.
ready1_o  output  1  requester 1 ready.
v_o  output  1  output valid.
data_o  output  width_p  muxed data; per bit, sel_o[b] ? data1_i[b] : data0_i[b].
last_o  output  1  last flag of the granted requester.
ready_i  input  1  downstream ready.
sel_o  output  width_p  gatestack select vector, every bit = current grant.

Behaviour:
- Reset is asynchronous on a falling reset_n_i and released synchronously to clk_i.
- Reset values:
  - state = IDLE, prio_r = 0 (requester 0 favoured).
  - v_o = 0, ready0_o = ready1_o = 0, sel_o = 0, data_o = data0_i (combinational).
- States: IDLE, LOCK0, LOCK1.
- All outputs are combinational from the current state, prio_r and inputs. There is zero-cycle latency from input valid to v_o.
- IDLE:
  - Candidate grant g:
    - Only v0_i set: g = 0.
    - Only v1_i set: g = 1.
    - Both set: g = prio_r.
    - Neither set: g = prio_r and v_o = 0.
  - sel_o = {width_p{g}}, v_o = v_g_i, last_o = last_g_i, ready_g_o = ready_i, other ready = 0.
- LOCKx: g = x fixed regardless of other requests. v_o = vx_i; readyx_o = ready_i; other ready = 0.
- Beat accepted = v_o & ready_i.
- Transitions:
  - IDLE, accept, last_g = 0, lock_p = 1 -> LOCKg.
  - IDLE, accept, last_g = 1 (or lock_p = 0) -> IDLE, prio_r <= ~g.
  - LOCKx, accept with lastx_i = 1 -> IDLE, prio_r <= ~x.
  - LOCKx, otherwise -> stay.
  - A gap in vx_i while locked keeps the lock; the other requester stays stalled.
- prio_r changes only on packet completion, never on a request alone.
- While ready_i = 0, grant and data_o are stable for a valid requester (no grant switching with v_o high).
- Simultaneous v0_i/v1_i on the same cycle as the winner's last-beat accept: the next cycle grants the other requester.
- A single-beat packet (last on first beat) never enters a LOCK state.
- Asserting reset mid-packet drops the lock immediately. The partially sent packet is not completed; requesters must re-send.
- Behaviour is undefined if the data, last or valid of the granted requester changes while v_o=1 and ready_i=0; protocol checkers flag this.

Optional Feature:
BSG_MUX2_RR_CTRL_STATS_EN:
- Defined:
  - Adds outputs pkt_cnt0_o and pkt_cnt1_o (16 bits each), counting completed packets per requester (last-beat accepts).
  - Each counter saturates at 0xFFFF and resets to 0.
  - Adds input stats_clr_i, which synchronously zeros both counters. A clear takes priority over an increment in the same cycle.
- Undefined: no counters, no extra ports, and identical arbitration behaviour.

Test Plan:
- Reset with both valid high -> ready0_o = ready1_o = 0 and v_o = 0 during reset. First post-reset cycle grants requester 0 (sel_o = 3'b000).
- Both requesters send continuous 1-beat packets with ready_i = 1 -> grants alternate 0,1,0,1 and sel_o alternates 000/111. data_o equals each winner's data that cycle.
- Requester 0 sends 3 beats (A,B,C; last on C) with v1_i held high -> data_o = A,B,C then requester 1. ready1_o = 0 for all three cycles.
- Locked to requester 1, drop v1_i for 2 cycles mid-packet while v0_i = 1 -> v_o = 0 and no grant to requester 0. Lock resumes when v1_i returns.
- Hold ready_i = 0 for 4 cycles with both valid -> sel_o, data_o and prio_r are unchanged. Raise ready_i -> exactly one beat is accepted from the prio_r requester.
- With BSG_MUX2_RR_CTRL_STATS_EN: complete 5 packets on requester 0 and 2 on requester 1 -> counters read 5 and 2. Pulse stats_clr_i -> both read 0 the next cycle.
